cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Shares the two-lane common data bus among NUM_REQ result producers: ALU, load/store buffer, branch unit, and a spare port.
- Each producer pushes {tag, data} results into a small private FIFO.
- Every cycle the arbiter grants up to two FIFO heads in round-robin order and drives the registered 74-bit cdb bus consumed by the reservation station, ROB and LSB.
- Flush discards all buffered results.

Parameters:
- NUM_REQ, 4, number of producer ports; legal range 2..8.
- FIFO_DEPTH, 2, entries per producer FIFO; must be a power of two, at least 2.
- TAG_W, 4, result tag width (matches 16-entry station and ROB).
- DATA_W, 32, result data width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low = freeze all state
- flush  in  1  mispredict flush; discard all buffered results
- req_valid  in  NUM_REQ  producer i has a result this cycle
- req_tag  in  NUM_REQ*TAG_W  producer i tag at [i*TAG_W +: TAG_W]
- req_data  in  NUM_REQ*DATA_W  producer i data at [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  FIFO i can accept this cycle
- cdb  out  74  lane0 = {valid[36], tag[35:32], data[31:0]}; lane1 = {valid[73], tag[72:69], data[68:37]}

Behaviour:
- Reset (rst=1 at posedge):
  - cdb=0, all FIFO counts/pointers=0, rr_ptr=0.
  - req_ready=0 while rst is high; all ones from the first cycle after.
- rdy=0: no accept, no grant, no flush effect. cdb, FIFOs and rr_ptr all hold. rst overrides rdy.
- req_ready[i]:
  - Combinational from registered state: (count_i < FIFO_DEPTH) && !rst.
  - No full-and-dequeue bypass: a full FIFO shows ready=0 even in a cycle it will be granted.
- Accept: at posedge with rdy && req_valid[i] && req_ready[i] && !flush, push {tag, data} into FIFO i.
  - req_valid with ready=0 is ignored; producer must hold its result.
- Grant (rdy && !flush):
  - Scan indices rr_ptr, rr_ptr+1, … mod NUM_REQ over FIFOs non-empty at cycle start.
  - First non-empty → lane0; second → lane1; both popped at the edge.
  - A result accepted at the same edge is not eligible.
- cdb register: lanes not granted get valid=0, and their tag/data are driven to 0.
- rr_ptr update:
  - Next rr_ptr = (index of last granted FIFO + 1) mod NUM_REQ.
  - Unchanged if nothing is granted.
- Latency: result accepted at edge N is visible on cdb no earlier than after edge N+1 (one cycle in FIFO, one register stage).
- Throughput: 2 results/cycle aggregate; any single producer is granted at most once per cycle.
- Flush (rdy=1, flush=1):
  - Overrides accept and grant.
  - All FIFOs emptied, cdb valid bits cleared to 0 at that edge, rr_ptr reset to 0.
- Lane ordering: lane0 always carries the earlier producer in the round-robin scan; consumers treat lanes equally.
- Invariants:
  - The two lanes never carry the same FIFO entry.
  - count_i never exceeds FIFO_DEPTH.
  - FIFO head/tail pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Shared package cpu_pkg:
  - CDB_LANE_W=37, CDB_W=74.
  - Field offsets: CDB_VALID0=36, CDB_TAG0_LSB=32, CDB_VALID1=73, CDB_TAG1_LSB=69, CDB_DATA1_LSB=37.
  - TAG_W, DATA_W defaults and producer index constants (REQ_ALU=0, REQ_LSB=1, REQ_BR=2).
- Sub-module cdb_req_fifo:
  - Single-producer, single-consumer FIFO of {tag, data}.
  - Ports: push, pop, flush, count, head outputs.
  - Instantiated NUM_REQ times via generate.
- The round-robin two-grant selector stays inline in cdb_arbiter.

Test Plan:
1. Reset: rst=1 for 2 cycles with req_valid=4'b1111 → cdb=0 and req_ready=0 during reset; req_ready=4'b1111 on the first cycle after.
2. Single producer: ALU pushes tag=3, data=0x0000_00AA at edge N → after edge N+1, cdb[36]=1, cdb[35:32]=3, cdb[31:0]=0xAA, cdb[73]=0; the next cycle cdb[36]=0.
3. Three producers, one cycle: ALU tag=1, LSB tag=2, BR tag=5, rr_ptr=0 → first grant lane0=tag1, lane1=tag2, rr_ptr=2; next cycle lane0=tag5, lane1 invalid, rr_ptr=3.
4. Backpressure: LSB pushes tags 7, 8 back-to-back while ALU, BR and port3 keep 3 FIFOs non-empty → LSB req_ready drops to 0 once count=2; a third push with ready=0 is dropped; tags 7, 8 eventually appear exactly once each, in order.
5. Flush: 3 results buffered, flush=1 for one cycle with req_valid[0]=1, tag=9 → cdb valid bits 0 after that edge; tag 9 never appears; all req_ready=1 next cycle.
6. rdy stall: drive rdy=0 for 3 cycles with cdb lane0 holding tag=4 and 2 results buffered → cdb, req_ready and buffers unchanged; on rdy=1, grants resume from the held rr_ptr.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: CDB lane layout, default result widths, producer ids.
package cpu_pkg;
  localparam int DEF_TAG_W  = 4;
  localparam int DEF_DATA_W = 32;

  localparam int CDB_LANE_W    = 1 + DEF_TAG_W + DEF_DATA_W;
  localparam int CDB_W         = 2 * CDB_LANE_W;
  localparam int CDB_VALID0    = 36;
  localparam int CDB_TAG0_LSB  = 32;
  localparam int CDB_VALID1    = 73;
  localparam int CDB_TAG1_LSB  = 69;
  localparam int CDB_DATA1_LSB = 37;

  typedef enum int {
    REQ_ALU   = 0,
    REQ_LSB   = 1,
    REQ_BR    = 2,
    REQ_SPARE = 3
  } req_id_e;

  // Single-step modulo for round-robin scans where i < 2*n.
  function automatic int rr_wrap(int i, int n);
    return (i >= n) ? i - n : i;
  endfunction
endpackage

// File: rtl/cdb_req_fifo.sv
// Per-producer result FIFO of {tag, data}; pointers wrap modulo DEPTH.
module cdb_req_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 36
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           wdata,
  output logic [$clog2(DEPTH):0] count,
  output logic [W-1:0]           head
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wp, r_rp;
  logic [PTR_W:0]   r_cnt;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (push) r_wp <= r_wp + 1'b1;
      if (pop)  r_rp <= r_rp + 1'b1;
      case ({push, pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wp] <= wdata;
  end

  assign count = r_cnt;
  assign head  = r_mem[r_rp];
endmodule

// File: rtl/cdb_arbiter.sv
// Two-lane common data bus arbiter: per-producer FIFOs, round-robin pick of up
// to two heads per cycle, registered 74-bit bus.
module cdb_arbiter
  import cpu_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_W      = DEF_TAG_W,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         flush,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]     req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [2*(1+TAG_W+DATA_W)-1:0] cdb
);
  localparam int ENT_W  = TAG_W + DATA_W;
  localparam int LANE_W = ENT_W + 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W  = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0][CNT_W-1:0] w_count;
  logic [NUM_REQ-1:0][ENT_W-1:0] w_head;
  logic [NUM_REQ-1:0]            w_nonempty, w_push, w_pop;
  logic                          w_flush, w_adv;
  logic                          w_g0_vld, w_g1_vld;
  logic [IDX_W-1:0]              w_g0_idx, w_g1_idx, w_s, w_rr_nxt;
  logic [IDX_W-1:0]              r_rr;
  logic [LANE_W-1:0]             w_lane0, w_lane1;
  logic [2*LANE_W-1:0]           r_cdb;

  assign w_flush = rdy & flush;
  assign w_adv   = rdy & ~flush;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign w_nonempty[gi] = (w_count[gi] != '0);
    // No full-and-pop bypass: a full FIFO stalls its producer for the cycle.
    assign req_ready[gi]  = (w_count[gi] < CNT_W'(FIFO_DEPTH)) && !rst;
    assign w_push[gi]     = w_adv && req_valid[gi] && req_ready[gi];
    assign w_pop[gi]      = w_adv && ((w_g0_vld && (w_g0_idx == IDX_W'(gi))) ||
                                      (w_g1_vld && (w_g1_idx == IDX_W'(gi))));

    cdb_req_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (ENT_W)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push[gi]),
      .pop   (w_pop[gi]),
      .flush (w_flush),
      .wdata ({req_tag[gi*TAG_W +: TAG_W], req_data[gi*DATA_W +: DATA_W]}),
      .count (w_count[gi]),
      .head  (w_head[gi])
    );
  end

  // Scan from r_rr; first two non-empty FIFOs win lane0 then lane1.
  always_comb begin
    w_g0_vld = 1'b0;
    w_g1_vld = 1'b0;
    w_g0_idx = '0;
    w_g1_idx = '0;
    w_s      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_s = IDX_W'(rr_wrap(int'(r_rr) + k, NUM_REQ));
      if (w_nonempty[w_s]) begin
        if (!w_g0_vld) begin
          w_g0_vld = 1'b1;
          w_g0_idx = w_s;
        end else if (!w_g1_vld) begin
          w_g1_vld = 1'b1;
          w_g1_idx = w_s;
        end
      end
    end
  end

  assign w_rr_nxt = IDX_W'(rr_wrap(int'(w_g1_vld ? w_g1_idx : w_g0_idx) + 1, NUM_REQ));
  assign w_lane0  = w_g0_vld ? {1'b1, w_head[w_g0_idx]} : '0;
  assign w_lane1  = w_g1_vld ? {1'b1, w_head[w_g1_idx]} : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cdb <= '0;
      r_rr  <= '0;
    end else if (rdy) begin
      if (flush) begin
        r_cdb <= '0;
        r_rr  <= '0;
      end else begin
        r_cdb <= {w_lane1, w_lane0};
        if (w_g0_vld) r_rr <= w_rr_nxt;
      end
    end
  end

  assign cdb = r_cdb;
endmodule
